// File: rtl/vga_motion_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_motion_pkg
// Description : Shared types and constants for the VGA object motion
//               controller: FSM state encoding, axis direction and the
//               internal axis arithmetic width.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_motion_pkg;

    // Internal axis width: one bit wider than the 10-bit pixel coordinates so
    // that pos+step and pos+OBJECT_SIZE never wrap.
    localparam int AXIS_W = 11;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/motion_axis_step.sv
`default_nettype none
// ============================================================================
// Module      : motion_axis_step
// Description : Combinational single-axis move/bounce step. Advances the
//               position by step in the current direction and clamps to
//               [0, limit], flipping direction and flagging a bounce when a
//               wall is reached. A zero step never moves or bounces.
// Ports       : i_pos       current position
//               i_dir       current direction
//               i_step      pixels to move this frame (0..7)
//               i_limit     highest legal position
//               o_next_pos  position after the step
//               o_next_dir  direction after the step
//               o_bounce    1 when a wall was hit
// Revision    : 1.0 - initial release
// ============================================================================
module motion_axis_step
    import vga_motion_pkg::*;
(
    input  logic [AXIS_W-1:0] i_pos,
    input  dir_t              i_dir,
    input  logic [2:0]        i_step,
    input  logic [AXIS_W-1:0] i_limit,
    output logic [AXIS_W-1:0] o_next_pos,
    output dir_t              o_next_dir,
    output logic              o_bounce
);

    logic [AXIS_W-1:0] w_step_ext;
    logic [AXIS_W-1:0] w_sum;

    assign w_step_ext = AXIS_W'(i_step);
    assign w_sum      = i_pos + w_step_ext;

    always_comb begin
        o_next_pos = i_pos;
        o_next_dir = i_dir;
        o_bounce   = 1'b0;
        // A stationary object parked on a wall must not re-bounce every frame.
        if (i_step != 3'd0) begin
            if (i_dir == DIR_INC) begin
                if (w_sum >= i_limit) begin
                    o_next_pos = i_limit;
                    o_next_dir = DIR_DEC;
                    o_bounce   = 1'b1;
                end else begin
                    o_next_pos = w_sum;
                end
            end else begin
                if (i_pos <= w_step_ext) begin
                    o_next_pos = '0;
                    o_next_dir = DIR_INC;
                    o_bounce   = 1'b1;
                end else begin
                    o_next_pos = i_pos - w_step_ext;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_object_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_object_motion_ctrl
// Description : Per-frame motion controller for a square object on a 640x480
//               display. Detects the frame boundary from the VGA pixel
//               coordinates, computes the next position into shadow
//               registers and commits it in one cycle during vertical
//               blanking, so no frame shows a torn object. Also produces the
//               registered object_on flag for the colour datapath.
// Ports       : i_clock, i_reset        50 MHz clock, async active-high reset
//               i_pixel_en              25 MHz pixel strobe
//               i_pixel_X_pos/Y_pos     current pixel coordinates
//               i_speed, i_pause        per-frame step and hold control
//               o_obj_col, o_obj_row    committed top-left position
//               o_object_on             current pixel is inside the object
//               o_frame_tick            one-clock pulse on each commit
//               o_bounce_count          frames with a bounce, mod 256
// Revision    : 1.0 - initial release
// ============================================================================
module vga_object_motion_ctrl
    import vga_motion_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int OBJECT_SIZE = 40,
    parameter int INIT_COL    = 300,
    parameter int INIT_ROW    = 220,
    parameter int TRIGGER_ROW = 480
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_pixel_en,
    input  logic [9:0] i_pixel_X_pos,
    input  logic [9:0] i_pixel_Y_pos,
    input  logic [2:0] i_speed,
    input  logic       i_pause,
    output logic [9:0] o_obj_col,
    output logic [9:0] o_obj_row,
    output logic       o_object_on,
    output logic       o_frame_tick,
    output logic [7:0] o_bounce_count
);

    localparam logic [AXIS_W-1:0] c_limit_x  = AXIS_W'(H_RES - OBJECT_SIZE);
    localparam logic [AXIS_W-1:0] c_limit_y  = AXIS_W'(V_RES - OBJECT_SIZE);
    localparam logic [AXIS_W-1:0] c_size     = AXIS_W'(OBJECT_SIZE);
    localparam logic [AXIS_W-1:0] c_init_col = AXIS_W'(INIT_COL);
    localparam logic [AXIS_W-1:0] c_init_row = AXIS_W'(INIT_ROW);
    localparam logic [9:0]        c_trig_row = 10'(TRIGGER_ROW);

    state_t            r_state;
    state_t            w_state_next;

    logic [2:0]        r_eff_step;
    logic [AXIS_W-1:0] r_col;
    logic [AXIS_W-1:0] r_row;
    dir_t              r_dir_x;
    dir_t              r_dir_y;
    logic [7:0]        r_bounce_count;
    logic              r_frame_tick;
    logic              r_object_on;

    // Shadow registers filled in S_CALC and copied out in S_COMMIT.
    logic [AXIS_W-1:0] r_next_col;
    logic [AXIS_W-1:0] r_next_row;
    dir_t              r_next_dir_x;
    dir_t              r_next_dir_y;
    logic              r_bounce;

    logic              w_trigger;
    logic [AXIS_W-1:0] w_next_col;
    logic [AXIS_W-1:0] w_next_row;
    dir_t              w_next_dir_x;
    dir_t              w_next_dir_y;
    logic              w_bounce_x;
    logic              w_bounce_y;
    logic [AXIS_W-1:0] w_x;
    logic [AXIS_W-1:0] w_y;
    logic              w_inside;

    // Column 0 of the first blank line: the visible frame has just ended.
    assign w_trigger = i_pixel_en && (i_pixel_X_pos == 10'd0) &&
                       (i_pixel_Y_pos == c_trig_row);

    motion_axis_step u_axis_x (
        .i_pos      (r_col),
        .i_dir      (r_dir_x),
        .i_step     (r_eff_step),
        .i_limit    (c_limit_x),
        .o_next_pos (w_next_col),
        .o_next_dir (w_next_dir_x),
        .o_bounce   (w_bounce_x)
    );

    motion_axis_step u_axis_y (
        .i_pos      (r_row),
        .i_dir      (r_dir_y),
        .i_step     (r_eff_step),
        .i_limit    (c_limit_y),
        .o_next_pos (w_next_row),
        .o_next_dir (w_next_dir_y),
        .o_bounce   (w_bounce_y)
    );

    // FSM state register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; triggers outside S_WAIT are dropped, never queued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT:   if (w_trigger) w_state_next = S_CALC;
            S_CALC:   w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_WAIT;
            default:  w_state_next = S_WAIT;
        endcase
    end

    // Position/direction datapath
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_eff_step     <= 3'd0;
            r_col          <= c_init_col;
            r_row          <= c_init_row;
            r_dir_x        <= DIR_INC;
            r_dir_y        <= DIR_INC;
            r_bounce_count <= 8'd0;
            r_frame_tick   <= 1'b0;
            r_next_col     <= c_init_col;
            r_next_row     <= c_init_row;
            r_next_dir_x   <= DIR_INC;
            r_next_dir_y   <= DIR_INC;
            r_bounce       <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (w_trigger) begin
                        r_eff_step <= i_pause ? 3'd0 : i_speed;
                    end
                end
                S_CALC: begin
                    r_next_col   <= w_next_col;
                    r_next_row   <= w_next_row;
                    r_next_dir_x <= w_next_dir_x;
                    r_next_dir_y <= w_next_dir_y;
                    // A corner hit is a single bounce event.
                    r_bounce     <= w_bounce_x | w_bounce_y;
                end
                S_COMMIT: begin
                    r_col        <= r_next_col;
                    r_row        <= r_next_row;
                    r_dir_x      <= r_next_dir_x;
                    r_dir_y      <= r_next_dir_y;
                    r_frame_tick <= 1'b1;
                    if (r_bounce) begin
                        r_bounce_count <= r_bounce_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel hit test against the committed position, one clock of latency.
    assign w_x      = AXIS_W'(i_pixel_X_pos);
    assign w_y      = AXIS_W'(i_pixel_Y_pos);
    assign w_inside = (w_x >= r_col) && (w_x < r_col + c_size) &&
                      (w_y >= r_row) && (w_y < r_row + c_size);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_object_on <= 1'b0;
        end else begin
            r_object_on <= w_inside;
        end
    end

    assign o_obj_col      = r_col[9:0];
    assign o_obj_row      = r_row[9:0];
    assign o_object_on    = r_object_on;
    assign o_frame_tick   = r_frame_tick;
    assign o_bounce_count = r_bounce_count;

endmodule
`default_nettype wire

// File: doc/vga_object_motion_ctrl.md
Name: vga_object_motion_ctrl

Overview:
- Per-frame controller that moves and bounces the square object on the 640x480 display.
- Owns the object's top-left position and produces the registered object_on flag that feeds the colour datapath.
- Samples the VGA controller's pixel coordinates and pixel-enable strobe to detect frame boundaries.
- Updates position only during vertical blanking, through a shadow/commit sequence, so a frame never shows a torn object.

Parameters:
- H_RES, 640, visible columns.
- V_RES, 480, visible rows.
- OBJECT_SIZE, 40, square side in pixels.
- INIT_COL, 300, reset top-left column.
- INIT_ROW, 220, reset top-left row.
- TRIGGER_ROW, 480, row whose column-0 pixel marks the frame boundary (first blank line).

Ports:
- clock  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_en  in  1  25 MHz pixel strobe (high every other clock).
- pixel_X_pos  in  10  current pixel column from the VGA controller.
- pixel_Y_pos  in  10  current pixel row from the VGA controller.
- speed  in  3  pixels moved per frame on each axis; 0 = stationary.
- pause  in  1  1 = hold position; frame_tick still pulses.
- obj_col  out  10  committed top-left column.
- obj_row  out  10  committed top-left row.
- object_on  out  1  registered "current pixel inside object".
- frame_tick  out  1  one-clock pulse when a new position is committed.
- bounce_count  out  8  number of frames with at least one bounce, mod 256.

Behaviour:
- Reset (async, any state): obj_col=INIT_COL, obj_row=INIT_ROW, dir_x=right, dir_y=down, object_on=0, frame_tick=0, bounce_count=0, state=S_WAIT.
- Trigger condition: pixel_en=1 && pixel_X_pos==0 && pixel_Y_pos==TRIGGER_ROW, sampled on a clock edge.
- FSM, 3 states:
  - S_WAIT: on trigger, latch speed/pause into eff_step (0 if pause=1), then go to S_CALC.
  - S_CALC: register next_col, next_row, next_dirs and bounce flag from the axis units, then go to S_COMMIT.
  - S_COMMIT: on the next edge, write obj_col, obj_row, dirs and bounce_count; frame_tick=1 for exactly that following cycle; go to S_WAIT.
- Latency: new position is visible on outputs 3 clocks after the trigger edge.
- Triggers seen in S_CALC or S_COMMIT are ignored. No queuing.
- speed/pause changes outside the trigger edge have no effect until the next frame.
- Axis arithmetic uses 11-bit unsigned values internally; LIMIT = RES - OBJECT_SIZE (600 for X, 440 for Y).
  - Increasing direction: if pos+step >= LIMIT, then pos=LIMIT, dir flips, bounce=1; else pos=pos+step.
  - Decreasing direction: if pos <= step, then pos=0, dir flips, bounce=1; else pos=pos-step.
  - step=0: position unchanged, no bounce, even when the object sits exactly at a limit.
- bounce_count increments by 1 per committed frame in which either axis bounced (a corner hit counts once). It wraps 255 -> 0.
- object_on is updated every clock, with 1-clock latency from the coordinates:
  - 1 iff obj_col <= X < obj_col+OBJECT_SIZE and obj_row <= Y < obj_row+OBJECT_SIZE, using the committed position.
- Reset asserted mid-sequence aborts the update; no partial commit becomes visible.

Decomposition:
- Package vga_motion_pkg holds:
  - state_t enum {S_WAIT, S_CALC, S_COMMIT};
  - dir_t (1 bit: 0 = increasing, 1 = decreasing);
  - an AXIS_W=11 constant.
- One sub-module, motion_axis_step, is combinational: pos, dir, step, limit -> next_pos, next_dir, bounce. It is instantiated twice (X, Y) and has no clock.

Test Plan:
- Reset, then drive X=300,Y=220 -> obj_col=300, obj_row=220; object_on=1 one clock later. Drive X=340,Y=220 -> object_on=0.
- speed=4, pause=0, one trigger -> 3 clocks later obj_col=304, obj_row=224, frame_tick high exactly 1 clock, bounce_count=0.
- speed=4, 55 triggers -> obj_row=440, dir_y flips, bounce_count=1. Next trigger -> obj_row=436, obj_col=524.
- pause=1, speed=7, 3 triggers -> position unchanged, 3 frame_tick pulses, bounce_count unchanged.
- Assert reset during S_CALC after a trigger with speed=5 -> outputs immediately return to 300/220/0, and no frame_tick follows.
- Trigger presented with pixel_en=0, or a second trigger during S_CALC -> no position change; exactly one commit per accepted trigger.
